// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type for the bit-serial adder controller.
package serial_add_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/fulladder_HA.sv
// fulladder_HA: one-bit full adder built from two half-adder stages.
module fulladder_HA (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (p & ci);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder with valid/ready handshakes.
// Define SERIAL_ADD_SUB_EN to enable subtraction via the sub input.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, in_ready_q, out_valid_q, busy_q;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] b_d;
    logic             carry_d;

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert b and inject a carry of one.
    assign b_d     = sub ? ~b : b;
    assign carry_d = sub | cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_d        = b;
    assign carry_d    = cin;
`endif

    fulladder_HA u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    a_q        <= a;
                    b_q        <= b_d;
                    carry_q    <= carry_d;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of serial_add_ctrl against an arithmetic model.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {cout,sum}: plain integer arithmetic; subtraction reports no-borrow on cout.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        int r;
`ifdef SERIAL_ADD_SUB_EN
        if (s) begin
            r = int'(x) - int'(y);
            return {(r >= 0), W'(r)};
        end
`endif
        r = int'(x) + int'(y) + int'(c);
        return (W+1)'(r);
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input int hold, input bit churn);
        logic [W:0] exp;
        int lat;
        exp = model(ta, tb, tc, ts);
        check("idle_in_ready", in_ready, 1);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        check("run_busy", busy, 1);
        check("run_in_ready", in_ready, 0);
        while (!out_valid && lat < W + 4) begin
            if (churn) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, W);
        check("sum", sum, exp[W-1:0]);
        check("cout", cout, exp[W]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, exp[W-1:0]);
            check("hold_cout", cout, exp[W]);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        bit seen_valid;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        run_op(8'hA5, 8'h7E, 1'b1, 1'b0, 5, 1'b0);
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0);
        run_op(8'h01, 8'h02, 1'b0, 1'b1, 0, 1'b0);
        run_op(8'h33, 8'hC4, 1'b1, 1'b0, 1, 1'b1);

        // Abort mid-run: after five RUN edges, reset must drop everything.
        a = 8'hC3; b = 8'h5F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        seen_valid = out_valid;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen_valid |= out_valid;
        end
        check("abort_no_valid", seen_valid, 0);

        for (int i = 0; i < 25; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1, forming the operand-accept handshake.
REQ-005 SHALL have ports a input WIDTH and b input WIDTH (operands), cin input 1 (carry-in) and sub input 1 (subtract request, see REQ-021).
REQ-006 SHALL have ports out_valid output 1 and out_ready input 1, forming the result handshake.
REQ-007 SHALL have ports sum output WIDTH (result), cout output 1 (final carry) and busy output 1 (high in RUN).

Function
REQ-008 SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using one full-adder cell and one carry flop, one bit per cycle.
REQ-009 SHALL implement FSM states IDLE, RUN and DONE.
REQ-010 IDLE: in_ready=1; on an edge with in_valid=1, SHALL latch a, b and cin, clear the bit counter, and go to RUN.
REQ-011 RUN: each edge SHALL add bit[cnt], shift the sum bit in at the MSB end, update carry and increment cnt; after the edge with cnt==WIDTH-1 SHALL go to DONE.
REQ-012 Latency SHALL be exactly WIDTH cycles: if accept occurs at edge k, out_valid is high after edge k+WIDTH.
REQ-013 DONE: out_valid=1 and sum/cout stable; SHALL hold until an edge with out_ready=1, then go to IDLE.
REQ-014 in_ready SHALL be 0 in RUN and DONE; no new operand is accepted until the result handshake completes, so the minimum issue interval is WIDTH+2 cycles.
REQ-015 Inputs a, b, cin and sub SHALL be ignored outside the accept edge; changes during RUN do not affect the result.
REQ-016 out_valid SHALL not depend combinationally on out_ready, and in_ready SHALL not depend combinationally on in_valid.
REQ-017 Carry SHALL wrap naturally: overflow beyond WIDTH bits appears only on cout, and sum is modulo 2^WIDTH.

Reset
REQ-018 rst=1 at any edge SHALL force IDLE, clearing sum, cout, out_valid, busy, carry and cnt to 0; in_ready SHALL be 1 after the edge.
REQ-019 rst asserted during RUN or DONE SHALL discard the in-flight operation with no out_valid pulse.
REQ-020 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-021 Macro SERIAL_ADD_SUB_EN defined: when sub=1 at accept, SHALL use ~b and force carry-in to 1 (cin ignored), giving sum = a - b, with cout=1 meaning no borrow.
REQ-022 Macro SERIAL_ADD_SUB_EN undefined: the sub port SHALL remain present but be ignored, and the block performs addition only.

Structure
REQ-023 FSM state encoding type and the state constants SHALL live in the shared package serial_add_pkg.
REQ-024 The one-bit adder SHALL be the team's existing fulladder_HA cell, instantiated once as the only sub-module; no other adder logic is permitted.
REQ-025 Operand and sum shift registers, the carry flop and a clog2(WIDTH)-bit counter SHALL reside in serial_add_ctrl.

Verification (WIDTH=8)
REQ-026 Basic add: a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, out_valid exactly 8 cycles after accept.
REQ-027 Overflow and carry-in: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-028 Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum and cout stable, in_ready=0; accept completes on the first out_ready=1 edge, then IDLE.
REQ-029 Reset mid-op: assert rst after bit 4 of RUN -> next cycle IDLE, all outputs 0, and no out_valid seen.
REQ-030 With SERIAL_ADD_SUB_EN: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1; a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
REQ-031 Input churn: change a and b every cycle during RUN -> result matches the values latched at accept.
